br_ram_port_arbiter: RTL

// - Shares one tiled-RAM address/data path between NumRequesters independent requesters.
// - Round-robin arbitration with a valid/ready handshake per requester.
// - Output drives the address decoder input (valid/addr/data) directly; that path has no backpressure.
// - One request is granted per cycle; the stall input suspends granting for RAM maintenance windows.

---
 rtl/br_ram_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/br_ram_port_arbiter.sv
// br_ram_port_arbiter: round-robin share of one tiled-RAM address/data path
// between NumRequesters valid/ready requesters. Output feeds the address
// decoder directly and has no backpressure; stall suspends granting.
// Optional build macro BR_RAM_PORT_ARB_OUTPUT_REG_EN: when defined the out_*
// bus is flopped (latency 1), otherwise it is combinational from the winner.

// Per-requester slice of the one-hot AND-OR output mux.
module br_ram_port_arbiter_lane #(
  parameter int AddressWidth = 1,
  parameter int DataWidth    = 1
) (
  input  logic                    sel_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    data_i,
  output logic [AddressWidth-1:0] addr_o,
  output logic [DataWidth-1:0]    data_o
);
  assign addr_o = sel_i ? addr_i : '0;
  assign data_o = sel_i ? data_i : '0;
endmodule

module br_ram_port_arbiter #(
  parameter  int NumRequesters = 2,
  parameter  int Depth         = 2,
  parameter  int DataWidth     = 1,
  localparam int AddressWidth  = $clog2(Depth)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NumRequesters-1:0]                  req_valid,
  output logic [NumRequesters-1:0]                  req_ready,
  input  logic [NumRequesters-1:0][AddressWidth-1:0] req_addr,
  input  logic [NumRequesters-1:0][DataWidth-1:0]    req_data,
  input  logic                                      stall,
  output logic                                      out_valid,
  output logic [AddressWidth-1:0]                   out_addr,
  output logic [DataWidth-1:0]                      out_data,
  output logic [NumRequesters-1:0]                  out_grant
);
  localparam int PtrW = $clog2(NumRequesters);

  logic [PtrW-1:0]                          ptr_q, ptr_d;
  logic [PtrW-1:0]                          win_idx;
  logic                                     found;
  logic [NumRequesters-1:0]                 gnt;
  logic [NumRequesters-1:0][AddressWidth-1:0] lane_addr;
  logic [NumRequesters-1:0][DataWidth-1:0]    lane_data;
  logic [AddressWidth-1:0]                  mux_addr;
  logic [DataWidth-1:0]                     mux_data;

  // Search valid requesters starting at ptr, wrapping modulo NumRequesters.
  always_comb begin
    int j;
    found   = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 0; k < NumRequesters; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NumRequesters) j = j - NumRequesters;
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        win_idx = PtrW'(j);
      end
    end
  end

  // Single winner, suppressed during stall and reset.
  always_comb begin
    gnt = '0;
    if (found && !stall && !rst) gnt[win_idx] = 1'b1;
  end

  assign req_ready = gnt;

  // Pointer moves just past the winner; held when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) ptr_d = (win_idx == PtrW'(NumRequesters - 1)) ? '0 : win_idx + PtrW'(1);
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // One mux slice per requester; non-selected lanes contribute zero.
  for (genvar g = 0; g < NumRequesters; g++) begin : g_lane
    br_ram_port_arbiter_lane #(
      .AddressWidth(AddressWidth),
      .DataWidth   (DataWidth)
    ) u_lane (
      .sel_i (gnt[g]),
      .addr_i(req_addr[g]),
      .data_i(req_data[g]),
      .addr_o(lane_addr[g]),
      .data_o(lane_data[g])
    );
  end

  // OR-combine the masked lanes into the granted address/data.
  always_comb begin
    mux_addr = '0;
    mux_data = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      mux_addr = mux_addr | lane_addr[i];
      mux_data = mux_data | lane_data[i];
    end
  end

`ifdef BR_RAM_PORT_ARB_OUTPUT_REG_EN
  logic                     out_valid_q;
  logic [NumRequesters-1:0] out_grant_q;
  logic [AddressWidth-1:0]  out_addr_q;
  logic [DataWidth-1:0]     out_data_q;

  // Registered decoder bus; addr/data only reload on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_grant_q <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= |gnt;
      out_grant_q <= gnt;
      if (|gnt) begin
        out_addr_q <= mux_addr;
        out_data_q <= mux_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_grant = out_grant_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

  a_accept_lat1: assert property (@(posedge clk) disable iff (rst)
    (|gnt) |=> (out_valid && out_addr == $past(mux_addr) && out_data == $past(mux_data)));
`else
  assign out_valid = |gnt;
  assign out_grant = gnt;
  assign out_addr  = mux_addr;
  assign out_data  = mux_data;

  a_accept_lat0: assert property (@(posedge clk) out_valid == |(req_valid & req_ready));
`endif

  a_rdy_onehot0: assert property (@(posedge clk) $onehot0(req_ready));
  a_grant_oh:    assert property (@(posedge clk) $onehot(out_grant) == out_valid);
  a_addr_range:  assert property (@(posedge clk) out_valid |-> (32'(out_addr) < 32'(Depth)));

endmodule
